// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM states,
// default geometry/latency and the address-check field widths.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int DEF_LATENCY     = 2;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int ALIGN_W         = 2;   // byte-offset bits that must be zero
    localparam int IDX_W           = ADDR_W - ALIGN_W;
    localparam int CNT_W           = 4;   // holds LATENCY up to 15
endpackage

// File: rtl/mem_word_array.sv
// Word storage: synchronous write, combinational read.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WORD_W      = DATA_W,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with fixed access latency,
// alignment/range checking and a held response until handshake.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY     = DEF_LATENCY,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_we,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] DEPTH_LIM = IDX_W'(DEPTH_WORDS);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [AW-1:0]     lat_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              lat_err;

    logic              req_err;
    logic              execute;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    assign req_err = (req_addr[ALIGN_W-1:0] != '0) ||
                     (req_addr[ADDR_W-1:ALIGN_W] >= DEPTH_LIM);
    assign execute = (state == WAIT) && (cnt == CNT_W'(1));
    // Reset must win over the execute edge so a pending store is dropped.
    assign wr_en   = execute && !reset && lat_we && !lat_err;

    mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .WORD_W(DATA_W)) u_array (
        .clock (clock),
        .we    (wr_en),
        .waddr (lat_idx),
        .wdata (lat_wdata),
        .raddr (lat_idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state     <= WAIT;
                    cnt       <= CNT_W'(LATENCY);
                    req_ready <= 1'b0;
                    lat_idx   <= req_addr[AW+ALIGN_W-1:ALIGN_W];
                    lat_wdata <= req_wdata;
                    lat_we    <= req_we;
                    lat_err   <= req_err;
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= lat_err;
                        resp_rdata <= (!lat_err && !lat_we) ? rd_word : '0;
                    end
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=2 instance for the main
// scenarios, LATENCY=1 instance for the back-to-back stream.
module tb_mem_responder;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1, req_wdata1, resp_rdata1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc;
    exp_t sb[$];
    logic [31:0] model0 [int];
    logic [31:0] model1 [int];

    always @(posedge clock) cyc <= cyc + 1;

    mem_responder #(.LATENCY(2), .DEPTH_WORDS(256)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .req_wdata(req_wdata1), .req_we(req_we1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    function automatic exp_t predict0(input logic [31:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        e.err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        e.rdata = '0;
        if (!e.err) begin
            if (w) model0[int'(a[31:2])] = d;
            else if (model0.exists(int'(a[31:2]))) e.rdata = model0[int'(a[31:2])];
        end
        return e;
    endfunction

    // Waits for req_ready, presents one request for a single edge.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
        int n = 0;
        @(negedge clock);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready got=%b want=1", req_ready);
        end
        req_valid = 1'b1; req_addr = a; req_we = w; req_wdata = d;
        acc_cyc = cyc + 1;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for resp_valid; outputs must stay quiet meanwhile.
    task automatic collect(output int lat, output logic [31:0] rd, output logic er);
        int n = 0;
        bit noisy = 0;
        while (resp_valid !== 1'b1 && n < 30) begin
            if (resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b0) noisy = 1;
            @(negedge clock);
            n++;
        end
        checks++;
        if (resp_valid !== 1'b1 || noisy) begin
            failures++;
            $display("FAIL wait_resp valid=%b quiet_violation=%0d want valid=1 quiet", resp_valid, noisy);
        end
        lat = cyc - acc_cyc;
        rd  = resp_rdata;
        er  = resp_err;
    endtask

    task automatic ack;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h e=%b want 0/0/0", resp_valid, resp_rdata, resp_err);
        end
        checks++;
        if (req_ready !== 1'b1 || req_ready1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b/%b want=1/1", req_ready, req_ready1);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_load;
        int lat; logic [31:0] rd; logic er; exp_t e;
        sb.push_back(predict0(32'h10, 1'b0, 32'h0));
        issue(32'h10, 1'b0, 32'h0);
        collect(lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL basic_latency got=%0d want=2", lat); end
        checks++;
        if (rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL basic_load got=%h/%b want=%h/%b", rd, er, e.rdata, e.err);
        end
        ack();
    endtask

    task automatic test_store_load;
        logic [31:0] a [2] = '{32'h40, 32'h40};
        logic        w [2] = '{1'b1, 1'b0};
        int lat; logic [31:0] rd; logic er; exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(predict0(a[i], w[i], 32'hDEAD_BEEF));
            issue(a[i], w[i], 32'hDEAD_BEEF);
            collect(lat, rd, er);
            e = sb.pop_front();
            checks++;
            if (lat !== 2 || rd !== e.rdata || er !== e.err) begin
                failures++;
                $display("FAIL store_load[%0d] got lat=%0d %h/%b want lat=2 %h/%b", i, lat, rd, er, e.rdata, e.err);
            end
            ack();
        end
    endtask

    task automatic test_errors;
        logic [31:0] a [3] = '{32'h42, 32'h400, 32'h0};
        logic        w [3] = '{1'b0, 1'b1, 1'b0};
        int lat; logic [31:0] rd; logic er; exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(predict0(a[i], w[i], 32'hFFFF_FFFF));
            issue(a[i], w[i], 32'hFFFF_FFFF);
            collect(lat, rd, er);
            e = sb.pop_front();
            checks++;
            if (lat !== 2 || rd !== e.rdata || er !== e.err) begin
                failures++;
                $display("FAIL errors[%0d] got lat=%0d %h/%b want lat=2 %h/%b", i, lat, rd, er, e.rdata, e.err);
            end
            ack();
        end
    endtask

    task automatic test_stall;
        int lat; logic [31:0] rd; logic er; exp_t e;
        sb.push_back(predict0(32'h40, 1'b0, 32'h0));
        issue(32'h40, 1'b0, 32'h0);
        collect(lat, rd, er);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] got v=%b %h/%b rdy=%b want v=1 %h/%b rdy=0",
                         i, resp_valid, resp_rdata, resp_err, req_ready, e.rdata, e.err);
            end
            req_valid = 1'b1; req_addr = 32'h80; req_we = 1'b1; req_wdata = 32'h5555_5555;
            @(negedge clock);
        end
        req_valid = 1'b0;
        ack();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got rdy=%b v=%b want rdy=1 v=0", req_ready, resp_valid);
        end
        // The store pulsed during the stall must not have landed.
        sb.push_back(predict0(32'h80, 1'b0, 32'h0));
        issue(32'h80, 1'b0, 32'h0);
        collect(lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL stall_ignored got=%h/%b want=%h/%b", rd, er, e.rdata, e.err);
        end
        ack();
    endtask

    task automatic test_reset_wait;
        int lat; logic [31:0] rd; logic er; exp_t e;
        bit rose = 0;
        sb.push_back(predict0(32'h8, 1'b1, 32'hAAAA_5555));
        issue(32'h8, 1'b1, 32'hAAAA_5555);
        collect(lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL rstwait_prestore got=%h/%b want=%h/%b", rd, er, e.rdata, e.err);
        end
        ack();
        // Not predicted: this store is killed by reset on its execute edge.
        issue(32'h8, 1'b1, 32'h1234_5678);
        @(negedge clock);
        if (resp_valid !== 1'b0) rose = 1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL rstwait_ready got=%b want=1", req_ready); end
        repeat (4) begin
            if (resp_valid !== 1'b0) rose = 1;
            @(negedge clock);
        end
        checks++;
        if (rose) begin failures++; $display("FAIL rstwait_valid got=1 want=0"); end
        sb.push_back(predict0(32'h8, 1'b0, 32'h0));
        issue(32'h8, 1'b0, 32'h0);
        collect(lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL rstwait_kept got=%h/%b want=%h/%b", rd, er, e.rdata, e.err);
        end
        ack();
    endtask

    task automatic test_back_to_back;
        int n = 0, got = 0, prev = -1, budget = 0, acc;
        int accq[$];
        exp_t q1[$];
        exp_t e;
        logic [31:0] a, d;
        logic w;
        resp_ready1 = 1'b1;
        while ((n < 8 || got < 8) && budget < 200) begin
            @(negedge clock);
            budget++;
            if (resp_valid1 === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected got resp want none");
                end else begin
                    e = q1.pop_front();
                    acc = accq.pop_front();
                    if (cyc - acc != 1 || resp_rdata1 !== e.rdata || resp_err1 !== e.err) begin
                        failures++;
                        $display("FAIL b2b_resp[%0d] got lat=%0d %h/%b want lat=1 %h/%b",
                                 got, cyc - acc, resp_rdata1, resp_err1, e.rdata, e.err);
                    end
                end
                got++;
            end
            if (n < 8) begin
                a = 32'h100 + 32'((n % 4) * 4);
                w = (n < 4);
                d = 32'hC0DE_0000 + 32'(n);
                req_valid1 = 1'b1; req_addr1 = a; req_we1 = w; req_wdata1 = d;
                if (req_ready1 === 1'b1) begin
                    if (prev >= 0) begin
                        checks++;
                        if (cyc + 1 - prev != 3) begin
                            failures++;
                            $display("FAIL b2b_spacing[%0d] got=%0d want=3", n, cyc + 1 - prev);
                        end
                    end
                    prev = cyc + 1;
                    accq.push_back(prev);
                    e.err = 1'b0;
                    e.rdata = '0;
                    if (w) model1[int'(a[31:2])] = d;
                    else if (model1.exists(int'(a[31:2]))) e.rdata = model1[int'(a[31:2])];
                    q1.push_back(e);
                    n++;
                end
            end else begin
                req_valid1 = 1'b0;
            end
        end
        checks++;
        if (got != 8 || n != 8) begin
            failures++;
            $display("FAIL b2b_count got=%0d/%0d want=8/8", n, got);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; resp_ready = 1'b0;
        req_valid1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_we1 = 1'b0; resp_ready1 = 1'b0;
        test_reset();
        test_basic_load();
        test_store_load();
        test_errors();
        test_stall();
        test_reset_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to response valid; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored; power of two.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address of the request.
REQ-008 req_wdata  input  32  store data; ignored for loads.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 resp_valid  output  1  response is present.
REQ-011 resp_ready  input  1  initiator accepts the response.
REQ-012 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 FSM states are IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 A request is accepted on an edge where req_valid=1 and req_ready=1; addr, wdata and we are latched; state moves to WAIT; the latency counter loads LATENCY.
REQ-016 In WAIT the counter decrements every cycle; at the edge where it decrements from 1, the access executes and the state moves to RESP.
REQ-017 For a request accepted at edge k, resp_valid SHALL first be 1 in the cycle after edge k+LATENCY.
REQ-018 Error: resp_err=1 when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; on error no write occurs and resp_rdata=0.
REQ-019 Load without error: resp_rdata = word at index addr[31:2], sampled at the execute edge.
REQ-020 Store without error: the word at addr[31:2] is written with wdata at the execute edge; resp_rdata=0 and resp_err=0.
REQ-021 In RESP, resp_valid, resp_rdata and resp_err SHALL remain stable until an edge with resp_ready=1; that edge returns the state to IDLE.
REQ-022 No request is accepted in the same cycle as a response handshake; minimum spacing between accepted requests is LATENCY+2 cycles.
REQ-023 req_valid in WAIT or RESP SHALL be ignored, with no latching and no side effects.
REQ-024 resp_valid SHALL be 0 in IDLE and WAIT; resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-025 resp_ready asserted outside RESP has no effect.
REQ-026 A read following a write to the same address returns the new data.

Reset
REQ-027 reset=1 at an edge forces IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 from the next cycle.
REQ-028 Reset has priority over every handshake; a request being accepted at a reset edge is dropped.
REQ-029 Reset in WAIT discards a store not yet executed; storage contents are otherwise unaffected by reset.

Structure
REQ-030 The shared package mem_pkg SHALL hold the state enum (IDLE, WAIT, RESP), the default LATENCY and DEPTH_WORDS constants, and the error-check width constants.
REQ-031 Sub-module mem_word_array SHALL hold DEPTH_WORDS x 32 storage with synchronous write and combinational read, sized by parameter; the FSM and counter live in mem_responder.

Verification
REQ-032 After reset, load 0x0000_0010 with LATENCY=2 accepted at edge 0 -> resp_valid=1 after edge 2, rdata=0, err=0.
REQ-033 Store 0xDEAD_BEEF to 0x0000_0040, then load 0x0000_0040 -> rdata=0xDEAD_BEEF, err=0.
REQ-034 Load 0x0000_0042 (misaligned) and store 0x0000_0400 (index 256 >= DEPTH) -> err=1, rdata=0; a later load of 0x0000_0400's alias 0x0 is unchanged.
REQ-035 Hold resp_ready=0 for 5 cycles in RESP -> outputs stable and req_ready=0 throughout; req_valid pulses are ignored; handshake on the 6th cycle -> req_ready=1 on the next cycle.
REQ-036 Reset in WAIT during a store of 0x1234_5678 to 0x8 -> resp_valid never rises, word 0x8 keeps its old value, and req_ready=1 after reset.
REQ-037 LATENCY=1 back-to-back stream of 8 requests with resp_ready tied to 1 -> each response arrives 1 cycle after acceptance, and accepted requests are spaced exactly 3 cycles apart.
